ascon_bdi_packer: RTL and testbench

- Upstream input stage for the Ascon core's bdi interface.
- Accepts a byte-serial stream tagged with segment type (key excluded: nonce, AD, message, tag) plus end-of-segment and end-of-input flags.
- Packs bytes into CCW-bit words with a per-byte valid mask, eot and eoi, and presents them on a valid/ready port that connects directly to the core's bdi_* inputs.
- Holds one word in an output register and packs the next word behind it, so a stalled core does not stall packing until both words are full.

---
 rtl/ascon_bdi_packer.sv | 170 +++++++++++++++++
 tb/tb_ascon_bdi_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_bdi_packer.sv
// Byte-serial to CCW-bit word packer feeding the Ascon core's bdi port.
// A pack register fills behind a one-word output register, so a stalled core only stalls input once both are full.
module ascon_bdi_packer #(
    parameter int CCW   = 32,
    parameter int CCWD8 = CCW / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [3:0]       s_type,
    input  logic             s_last,
    input  logic             s_eoi,
    output logic [CCW-1:0]   m_bdi,
    output logic [CCWD8-1:0] m_bdi_valid,
    input  logic             m_bdi_ready,
    output logic [3:0]       m_bdi_type,
    output logic             m_bdi_eot,
    output logic             m_bdi_eoi,
    output logic             err
);

    localparam int CW = $clog2(CCWD8 + 1);

    // Contiguous byte-valid mask with the low cnt bits set.
    function automatic logic [CCWD8-1:0] f_mask(input logic [CW-1:0] cnt);
        f_mask = '0;
        for (int i = 0; i < CCWD8; i++) begin
            f_mask[i] = (CW'(i) < cnt);
        end
    endfunction

    logic [CCW-1:0]   r_pk_data;
    logic [CW-1:0]    r_pk_cnt;
    logic [3:0]       r_pk_type;
    logic             r_pk_eot;
    logic             r_pk_eoi;
    logic             r_pk_complete;
    logic [CCW-1:0]   r_m_bdi;
    logic [CCWD8-1:0] r_m_valid;
    logic [3:0]       r_m_type;
    logic             r_m_eot;
    logic             r_m_eoi;
    logic             r_err;
    logic             r_eoi_seen;

    logic             w_out_free;
    logic             w_move;
    logic             w_s_ready;
    logic             w_accept;
    logic [CW-1:0]    w_base;
    logic [CCW-1:0]   w_pk_data_n;
    logic [CW-1:0]    w_pk_cnt_n;
    logic [3:0]       w_pk_type_n;
    logic             w_pk_eot_n;
    logic             w_pk_eoi_n;
    logic             w_pk_complete_n;
    logic             w_err_n;

    assign w_out_free = (r_m_valid == '0) || m_bdi_ready;
    assign w_move     = r_pk_complete && w_out_free;
    assign w_s_ready  = !r_pk_complete || w_out_free;
    assign w_accept   = s_valid && w_s_ready;
    // A byte arriving while the finished word leaves starts the next word at byte 0.
    assign w_base     = w_move ? CW'(0) : r_pk_cnt;

    // Next state of the pack register: clear on move, then place an accepted byte.
    always_comb begin
        w_pk_data_n     = r_pk_data;
        w_pk_cnt_n      = r_pk_cnt;
        w_pk_type_n     = r_pk_type;
        w_pk_eot_n      = r_pk_eot;
        w_pk_eoi_n      = r_pk_eoi;
        w_pk_complete_n = r_pk_complete;
        if (w_move) begin
            w_pk_data_n     = '0;
            w_pk_cnt_n      = '0;
            w_pk_type_n     = 4'd0;
            w_pk_eot_n      = 1'b0;
            w_pk_eoi_n      = 1'b0;
            w_pk_complete_n = 1'b0;
        end else begin
            w_pk_complete_n = r_pk_complete;
        end
        if (w_accept) begin
            for (int i = 0; i < CCWD8; i++) begin
                if (CW'(i) == w_base) begin
                    w_pk_data_n[8*i +: 8] = s_data;
                end else begin
                    w_pk_data_n[8*i +: 8] = w_pk_data_n[8*i +: 8];
                end
            end
            if (w_base == CW'(0)) begin
                w_pk_type_n = s_type;
            end else begin
                w_pk_type_n = r_pk_type;
            end
            w_pk_cnt_n      = w_base + CW'(1);
            w_pk_complete_n = (w_base + CW'(1) == CW'(CCWD8)) || s_last;
            w_pk_eot_n      = s_last;
            w_pk_eoi_n      = s_last && s_eoi;
        end else begin
            w_pk_cnt_n = w_pk_cnt_n;
        end
    end

    // Protocol errors are sticky; the offending byte is still packed.
    always_comb begin
        w_err_n = r_err;
        if (w_accept) begin
            if ((!w_move && (r_pk_cnt != CW'(0)) && (s_type != r_pk_type)) ||
                (s_eoi && !s_last) || r_eoi_seen) begin
                w_err_n = 1'b1;
            end else begin
                w_err_n = r_err;
            end
        end else begin
            w_err_n = r_err;
        end
    end

    // Pack, output and error state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pk_data     <= '0;
            r_pk_cnt      <= '0;
            r_pk_type     <= 4'd0;
            r_pk_eot      <= 1'b0;
            r_pk_eoi      <= 1'b0;
            r_pk_complete <= 1'b0;
            r_m_bdi       <= '0;
            r_m_valid     <= '0;
            r_m_type      <= 4'd0;
            r_m_eot       <= 1'b0;
            r_m_eoi       <= 1'b0;
            r_err         <= 1'b0;
            r_eoi_seen    <= 1'b0;
        end else begin
            r_pk_data     <= w_pk_data_n;
            r_pk_cnt      <= w_pk_cnt_n;
            r_pk_type     <= w_pk_type_n;
            r_pk_eot      <= w_pk_eot_n;
            r_pk_eoi      <= w_pk_eoi_n;
            r_pk_complete <= w_pk_complete_n;
            r_err         <= w_err_n;
            if (w_accept && s_last && s_eoi) begin
                r_eoi_seen <= 1'b1;
            end
            if (w_move) begin
                r_m_bdi   <= r_pk_data;
                r_m_valid <= f_mask(r_pk_cnt);
                r_m_type  <= r_pk_type;
                r_m_eot   <= r_pk_eot;
                r_m_eoi   <= r_pk_eoi;
            end else if (m_bdi_ready) begin
                r_m_valid <= '0;
            end
        end
    end

    assign s_ready     = w_s_ready;
    assign m_bdi       = r_m_bdi;
    assign m_bdi_valid = r_m_valid;
    assign m_bdi_type  = r_m_type;
    assign m_bdi_eot   = r_m_eot;
    assign m_bdi_eoi   = r_m_eoi;
    assign err         = r_err;

endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Self-checking bench for ascon_bdi_packer: directed scenarios plus a random
// segment stream scored against a queue-based word model (CCW=32, one CCW=64 case).
module tb_ascon_bdi_packer;

    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_AD    = 4'd2;
    localparam logic [3:0] D_MSG   = 4'd3;
    localparam logic [3:0] D_TAG   = 4'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic [3:0]  s_type = 4'd0;
    logic        s_last = 1'b0;
    logic        s_eoi = 1'b0;
    logic        m_bdi_ready = 1'b0;

    logic        s_ready;
    logic [31:0] m_bdi;
    logic [3:0]  m_bdi_valid;
    logic [3:0]  m_bdi_type;
    logic        m_bdi_eot, m_bdi_eoi, err;

    logic        s64_ready;
    logic [63:0] m64_bdi;
    logic [7:0]  m64_valid;
    logic [3:0]  m64_type;
    logic        m64_eot, m64_eoi, m64_err;

    ascon_bdi_packer #(.CCW(32)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_type(s_type), .s_last(s_last), .s_eoi(s_eoi), .m_bdi(m_bdi),
        .m_bdi_valid(m_bdi_valid), .m_bdi_ready(m_bdi_ready), .m_bdi_type(m_bdi_type),
        .m_bdi_eot(m_bdi_eot), .m_bdi_eoi(m_bdi_eoi), .err(err)
    );

    ascon_bdi_packer #(.CCW(64)) dut64 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s64_ready),
        .s_type(s_type), .s_last(s_last), .s_eoi(s_eoi), .m_bdi(m64_bdi),
        .m_bdi_valid(m64_valid), .m_bdi_ready(m_bdi_ready), .m_bdi_type(m64_type),
        .m_bdi_eot(m64_eot), .m_bdi_eoi(m64_eoi), .err(m64_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  m;
        logic [3:0]  t;
        logic        eot;
        logic        eoi;
    } word_t;

    word_t       exp_q[$];
    logic [7:0]  bld[$];
    logic [3:0]  bld_type;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic        prev_held = 1'b0;
    logic [63:0] prev_vec = 64'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: words end at 4 bytes or at a segment's last byte.
    task automatic model_byte(input logic [7:0] d, input logic [3:0] t, input logic l, input logic e);
        word_t w;
        if (bld.size() == 0) bld_type = t;
        bld.push_back(d);
        if (bld.size() == 4 || l) begin
            w.d = 32'd0;
            for (int i = 0; i < bld.size(); i++) w.d[8*i +: 8] = bld[i];
            w.m   = 4'((1 << bld.size()) - 1);
            w.t   = bld_type;
            w.eot = l;
            w.eoi = l && e;
            exp_q.push_back(w);
            bld.delete();
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [3:0] t,
                        input logic l, input logic e, input logic rdy, output logic acc);
        word_t w;
        @(negedge clk);
        s_valid = v; s_data = d; s_type = t; s_last = l; s_eoi = e; m_bdi_ready = rdy;
        #1;
        if (prev_held)
            chk("hold_stable", {22'd0, m_bdi_type, m_bdi_eot, m_bdi_eoi, m_bdi_valid, m_bdi}, prev_vec);
        if (m_bdi_valid != 4'd0 && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word_mask", {60'd0, m_bdi_valid}, 64'd0);
            end else begin
                w = exp_q.pop_front();
                chk("word", {22'd0, m_bdi_type, m_bdi_eot, m_bdi_eoi, m_bdi_valid, m_bdi},
                    {22'd0, w.t, w.eot, w.eoi, w.m, w.d});
            end
        end
        prev_held = (m_bdi_valid != 4'd0) && !rdy;
        prev_vec  = {22'd0, m_bdi_type, m_bdi_eot, m_bdi_eoi, m_bdi_valid, m_bdi};
        acc = v && s_ready;
        if (acc) model_byte(d, t, l, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.delete();
        bld.delete();
        prev_held = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, acc);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic acc;
        int   idx;
        int   tries;
        logic [3:0] types [4];
        types[0] = D_NONCE; types[1] = D_AD; types[2] = D_MSG; types[3] = D_TAG;

        // Reset state
        do_reset();
        chk("rst_outputs", {22'd0, m_bdi_type, m_bdi_eot, m_bdi_eoi, m_bdi_valid, m_bdi}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd1);

        // Eight AD bytes, core always ready: no s_ready drop
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h11 + i), D_AD, i == 7, 1'b0, 1'b1, acc);
            chk("t1_no_ready_drop", {63'd0, acc}, 64'd1);
        end
        drain();

        // Three MSG bytes with eoi, then a byte after eoi raises err
        do_reset();
        step(1'b1, 8'h11, D_MSG, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h22, D_MSG, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h33, D_MSG, 1'b1, 1'b1, 1'b1, acc);
        drain();
        chk("eoi_no_err", {63'd0, err}, 64'd0);
        step(1'b1, 8'h55, D_MSG, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, acc);
        chk("err_after_eoi", {63'd0, err}, 64'd1);

        // s_eoi without s_last
        do_reset();
        chk("rst_clears_err", {63'd0, err}, 64'd0);
        step(1'b1, 8'h01, D_TAG, 1'b0, 1'b1, 1'b1, acc);
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, acc);
        chk("err_eoi_no_last", {63'd0, err}, 64'd1);

        // Core stalled 20 cycles while 12 MSG bytes are offered
        do_reset();
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            step(idx < 12, 8'(8'h40 + idx), D_MSG, idx == 11, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("stall_accepted", 64'(idx), 64'd8);
        chk("stall_s_ready", {63'd0, s_ready}, 64'd0);
        tries = 0;
        while (idx < 12 && tries < 50) begin
            step(1'b1, 8'(8'h40 + idx), D_MSG, idx == 11, 1'b0, 1'b1, acc);
            if (acc) idx++;
            tries++;
        end
        chk("stall_release_all", 64'(idx), 64'd12);
        drain();

        // Type change mid-word
        do_reset();
        step(1'b1, 8'hA1, D_AD, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'hA2, D_AD, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'hA3, D_MSG, 1'b1, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, acc);
        chk("err_type_change", {63'd0, err}, 64'd1);
        drain();
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, acc);
        chk("err_sticky", {63'd0, err}, 64'd1);

        // Reset mid-word with an output word held
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), D_AD, 1'b0, 1'b0, 1'b0, acc);
        chk("pre_rst_held", {60'd0, m_bdi_valid}, 64'hF);
        do_reset();
        chk("midword_rst_valid", {60'd0, m_bdi_valid}, 64'd0);
        chk("midword_rst_ready", {63'd0, s_ready}, 64'd1);
        step(1'b1, 8'hB1, D_AD, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'hB2, D_AD, 1'b1, 1'b0, 1'b1, acc);
        drain();

        // Single NONCE byte: latency and the 64-bit instance
        do_reset();
        step(1'b1, 8'hAB, D_NONCE, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, acc);
        chk("latency_n1", {60'd0, m_bdi_valid}, 64'd0);
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, acc);
        chk("latency_n2", {60'd0, m_bdi_valid}, 64'h1);
        chk("c64_data", m64_bdi, 64'h0000_0000_0000_00AB);
        chk("c64_flags", {51'd0, m64_type, m64_eot, m64_eoi, m64_valid}, {51'd0, D_NONCE, 1'b1, 1'b0, 8'h01});
        drain();

        // Random segment stream with random gaps and backpressure
        do_reset();
        for (int seg = 0; seg < 30; seg++) begin
            int len;
            logic [3:0] t;
            len = $urandom_range(1, 11);
            t = types[$urandom_range(0, 3)];
            for (int b = 0; b < len; b++) begin
                acc = 1'b0;
                tries = 0;
                while (!acc && tries < 200) begin
                    step($urandom_range(0, 3) != 0, 8'($urandom), t, b == len - 1,
                         (b == len - 1) && (seg == 29), $urandom_range(0, 3) != 0, acc);
                    tries++;
                end
                if (!acc) chk("rand_accept_timeout", {63'd0, acc}, 64'd1);
            end
        end
        drain();
        chk("rand_no_err", {63'd0, err}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
